dmiss_req_seq: RTL and testbench
================================

# dmiss_req_seq

Miss-request sequencer sitting directly downstream of the L1D miss CAM (`dmisscam`). It scans the CAM's filled-entry vector and pulls each newly filled entry's line address out through the `ins_en`/`ins_req` port. It forwards each address to the L2 as a tagged line request over a valid/ready handshake and tracks outstanding tags until their fill responses return. After the CAM raises `begin_replay`, it produces the single-cycle `unlock` that frees the buffers and reopens the CAM.

## Interface
Parameters:
- ENTRIES, 16: miss-buffer count; must equal the CAM's entry count.
- TAG_W, 4: log2(ENTRIES); width of `ins_req` and the L2 tag.
- ADDR_W, 37: line address width (PADDR_WIDTH-7).
- TIMEOUT, 1023: watchdog limit in cycles; used only with DMISS_TIMEOUT_EN.

Ports (one clock; reset is synchronous and active-high):
- clk, in, 1: clock.
- rst, in, 1: synchronous active-high reset.
- miss_filled, in, ENTRIES: per-entry `filled` bits from the CAM.
- ins_addr_i, in, ADDR_W: CAM `ins_addr_o`; valid in the same cycle as `ins_en`.
- ins_en, out, 1: CAM extract strobe; combinational.
- ins_req, out, TAG_W: entry being extracted; combinational.
- l2_req_valid, out, 1: L2 request valid; registered.
- l2_req_addr, out, ADDR_W: L2 request line address; registered.
- l2_req_tag, out, TAG_W: L2 request tag, equal to the entry index; registered.
- l2_req_ready, in, 1: L2 accepts the request.
- l2_rsp_valid, in, 1: L2 fill response valid.
- l2_rsp_tag, in, TAG_W: tag of the returned fill.
- begin_replay, in, 1: CAM replay start.
- replay_done, in, 1: replay read index has reached the stored write index.
- unlock, out, 1: CAM buffer release; one-cycle pulse; registered.
- outstanding, out, ENTRIES: tags sent to the L2 and not yet answered.
- err_spurious, out, 1: sticky; set by a response whose tag is not outstanding.
- err_timeout, out, 1: sticky watchdog flag; tied 0 when the macro is off.

## Operation
- Request pick:
  - `can_load` = ~`l2_req_valid` | `l2_req_ready`. The request register is either empty or being drained this cycle.
  - `pend` = `miss_filled` & ~`outstanding`.
  - When `can_load` and `pend` is non-zero, drive `ins_en`=1 and `ins_req`=k. k is the first set bit of `pend` at or above `rr_ptr`, wrapping past ENTRIES-1 to 0.
  - On that edge:
    - Load `l2_req_addr` from `ins_addr_i`.
    - Load `l2_req_tag` with k.
    - Set `l2_req_valid`.
    - Set `rr_ptr` to k+1 mod ENTRIES.
  - The CAM clears `filled[k]` on the same edge.
- Handshake:
  - `l2_req_valid`, `l2_req_addr` and `l2_req_tag` hold stable until `l2_req_ready`.
  - On the accept edge, set `outstanding[tag]`.
  - If nothing loads on that edge, clear `l2_req_valid`.
- Response:
  - `l2_rsp_valid` clears `outstanding[l2_rsp_tag]`.
  - If that bit was already 0, set `err_spurious` and change nothing else.
  - If an accept and a response name the same tag on the same edge, the set wins.
- Unlock FSM states:
  - RUN: go to REPLAY on `begin_replay`.
  - REPLAY: go to UNLK when `replay_done` and `outstanding`==0 and ~`l2_req_valid`.
  - UNLK: `unlock`=1 for exactly one cycle, then go to RUN.
- `begin_replay` seen in REPLAY or UNLK is ignored.
- Request issue continues in every FSM state.
- Reset values:
  - All outputs 0.
  - `rr_ptr`=0, FSM in RUN, error flags cleared.
  - Reset mid-transaction drops any pending request and clears `outstanding` without waiting.

## Timing
- `ins_en` to `l2_req_valid`: 1 cycle.
- Back-to-back issue: one request per cycle while `l2_req_ready` is held high.
- Request to `outstanding` bit set: 1 cycle after the accept edge.
- Response to `outstanding` bit clear: 1 cycle.
- REPLAY exit condition true to `unlock` high: 1 cycle.
- `unlock` to next possible REPLAY entry: 1 cycle.

## Configuration
- DMISS_TIMEOUT_EN defined:
  - A 10-bit (clog2(TIMEOUT+1)) counter increments each cycle while `outstanding` is non-zero and no response arrives.
  - It resets to 0 on any response and whenever `outstanding`==0.
  - When it reaches TIMEOUT, `err_timeout` is set and stays set until `rst`. The counter saturates.
- DMISS_TIMEOUT_EN undefined: no counter; `err_timeout` tied 0.

## Structure
- Shared package holds:
  - `dmiss_tag_t` (TAG_W bits) and `dmiss_addr_t` (ADDR_W bits).
  - The FSM enum {RUN, REPLAY, UNLK}.
  - The constant ENTRIES=16.
- One sub-module, `dmiss_rr_pick`: combinational rotate, find-first, unrotate.
  - Inputs: `pend`, `rr_ptr`.
  - Outputs: `found`, index.
- Everything else stays in the top module.

## Test plan
1. After reset, drive `miss_filled`=16'h0001, `ins_addr_i`=37'h12345 and `l2_req_ready`=1.
   - Cycle 0: `ins_en`=1, `ins_req`=0.
   - Cycle 1: `l2_req_valid`=1, `l2_req_addr`=37'h12345, `l2_req_tag`=0.
   - Cycle 2: `outstanding`=16'h0001.
2. Round robin: drive `miss_filled`=16'h8003 with `rr_ptr` starting at 0, and clear each bit one edge after its extract.
   - Required extract order: 0, 1, 15. `rr_ptr` then wraps to 0.
3. Hold `l2_req_ready`=0 for 5 cycles with two pending entries.
   - The request stays stable and `ins_en` stays 0.
   - On the ready cycle the second entry is extracted, so issue proceeds back-to-back.
4. Respond with `l2_rsp_tag`=3 while `outstanding`=0.
   - `err_spurious`=1 and `outstanding` stays unchanged.
   - A simultaneous accept and response on tag 2 leaves `outstanding[2]`=1.
5. Replay with tag 5 outstanding: pulse `begin_replay`, then hold `replay_done`=1.
   - `unlock` stays 0 until the tag-5 response.
   - `unlock` is then high for exactly 1 cycle, exactly 1 cycle later.
6. With DMISS_TIMEOUT_EN and TIMEOUT=8: one outstanding tag, no response.
   - `err_timeout` rises 8 cycles after the accept.
   - Reset mid-wait clears all outputs and the FSM returns to RUN.

Source files
------------

// File: rtl/dmiss_req_seq_pkg.sv
// rtl/dmiss_req_seq_pkg.sv - shared types and constants for the miss-request sequencer
//
// Contents:
//   ENTRIES       miss-buffer count (matches the dmisscam entry count)
//   DMISS_TAG_W   tag / entry-index width, log2(ENTRIES)
//   DMISS_ADDR_W  line address width
//   dmiss_tag_t   L2 request tag / CAM entry index
//   dmiss_addr_t  line address
//   dmiss_state_e unlock FSM states
package dmiss_req_seq_pkg;

    localparam int ENTRIES      = 16;
    localparam int DMISS_TAG_W  = 4;
    localparam int DMISS_ADDR_W = 37;

    typedef logic [DMISS_TAG_W-1:0]  dmiss_tag_t;
    typedef logic [DMISS_ADDR_W-1:0] dmiss_addr_t;

    typedef enum logic [1:0] {
        RUN    = 2'd0,
        REPLAY = 2'd1,
        UNLK   = 2'd2
    } dmiss_state_e;

endpackage

// File: rtl/dmiss_req_seq_if.sv
// rtl/dmiss_req_seq_if.sv - L2 line request / fill response bundle
//
// Signals:
//   l2_req_valid  request valid            (sequencer -> L2)
//   l2_req_addr   request line address     (sequencer -> L2)
//   l2_req_tag    request tag = entry idx  (sequencer -> L2)
//   l2_req_ready  L2 accepts the request   (L2 -> sequencer)
//   l2_rsp_valid  fill response valid      (L2 -> sequencer)
//   l2_rsp_tag    tag of returned fill     (L2 -> sequencer)
// Modports: master = sequencer side, slave = L2 side.
interface dmiss_req_seq_if
    import dmiss_req_seq_pkg::*;
#(
    parameter int TAG_W  = DMISS_TAG_W,
    parameter int ADDR_W = DMISS_ADDR_W
);

    logic              l2_req_valid;
    logic [ADDR_W-1:0] l2_req_addr;
    logic [TAG_W-1:0]  l2_req_tag;
    logic              l2_req_ready;
    logic              l2_rsp_valid;
    logic [TAG_W-1:0]  l2_rsp_tag;

    modport master (
        output l2_req_valid,
        output l2_req_addr,
        output l2_req_tag,
        input  l2_req_ready,
        input  l2_rsp_valid,
        input  l2_rsp_tag
    );

    modport slave (
        input  l2_req_valid,
        input  l2_req_addr,
        input  l2_req_tag,
        output l2_req_ready,
        output l2_rsp_valid,
        output l2_rsp_tag
    );

endinterface

// File: rtl/dmiss_req_seq_rr_pick.sv
// rtl/dmiss_req_seq_rr_pick.sv - round-robin first-set-bit picker
//
// Ports:
//   pend_i    in   ENTRIES  candidate entries
//   rr_ptr_i  in   TAG_W    search start position
//   found_o   out  1        any candidate set
//   idx_o     out  TAG_W    first set bit at or above rr_ptr_i, wrapping
module dmiss_rr_pick
    import dmiss_req_seq_pkg::*;
#(
    parameter int ENTRIES = dmiss_req_seq_pkg::ENTRIES,
    parameter int TAG_W   = DMISS_TAG_W
) (
    input  logic [ENTRIES-1:0] pend_i,
    input  logic [TAG_W-1:0]   rr_ptr_i,
    output logic               found_o,
    output logic [TAG_W-1:0]   idx_o
);

    logic [TAG_W-1:0] pos;

    // Walk the rotated view from the far end down so the entry nearest
    // rr_ptr_i is the last one written. The TAG_W-wide add is the unrotate
    // and gives the wrap past ENTRIES-1 for free (ENTRIES == 2**TAG_W).
    always_comb begin
        found_o = 1'b0;
        idx_o   = '0;
        pos     = '0;
        for (int i = ENTRIES - 1; i >= 0; i--) begin
            pos = rr_ptr_i + TAG_W'(i);
            if (pend_i[pos]) begin
                found_o = 1'b1;
                idx_o   = pos;
            end
        end
    end

endmodule

// File: rtl/dmiss_req_seq.sv
// rtl/dmiss_req_seq.sv - L1D miss-request sequencer between dmisscam and the L2
//
// Optional feature macro: DMISS_TIMEOUT_EN (outstanding-response watchdog).
//
// Ports:
//   clk           in   1        clock
//   rst           in   1        synchronous active-high reset
//   miss_filled   in   ENTRIES  per-entry filled bits from the CAM
//   ins_addr_i    in   ADDR_W   CAM line address for ins_req
//   ins_en        out  1        CAM extract strobe (combinational)
//   ins_req       out  TAG_W    entry being extracted (combinational)
//   l2            master       L2 request / response bundle (registered request)
//   begin_replay  in   1        CAM replay start
//   replay_done   in   1        CAM replay has caught up with the write index
//   unlock        out  1        one-cycle buffer release pulse (registered)
//   outstanding   out  ENTRIES  tags accepted by the L2 and not yet answered
//   err_spurious  out  1        sticky: response for a tag not outstanding
//   err_timeout   out  1        sticky watchdog flag (0 without DMISS_TIMEOUT_EN)
module dmiss_req_seq
    import dmiss_req_seq_pkg::*;
#(
    parameter int ENTRIES = dmiss_req_seq_pkg::ENTRIES,
    parameter int TAG_W   = DMISS_TAG_W,
    parameter int ADDR_W  = DMISS_ADDR_W,
    parameter int TIMEOUT = 1023
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [ENTRIES-1:0] miss_filled,
    input  logic [ADDR_W-1:0]  ins_addr_i,
    output logic               ins_en,
    output logic [TAG_W-1:0]   ins_req,
    dmiss_req_seq_if.master    l2,
    input  logic               begin_replay,
    input  logic               replay_done,
    output logic               unlock,
    output logic [ENTRIES-1:0] outstanding,
    output logic               err_spurious,
    output logic               err_timeout
);

    if (ENTRIES != (1 << TAG_W)) begin : g_bad_entries
        $error("dmiss_req_seq: ENTRIES must equal 2**TAG_W");
    end
    if (TIMEOUT < 1) begin : g_bad_timeout
        $error("dmiss_req_seq: TIMEOUT must be at least 1");
    end

    logic               req_valid_q;
    logic [ADDR_W-1:0]  req_addr_q;
    logic [TAG_W-1:0]   req_tag_q;
    logic [TAG_W-1:0]   rr_ptr_q;
    logic [ENTRIES-1:0] outstanding_q, outstanding_d;
    logic               err_spurious_q, err_spurious_d;
    dmiss_state_e       state_q;
    logic               unlock_q;

    logic               can_load;
    logic               accept;
    logic [ENTRIES-1:0] pend;
    logic               pick_found;
    logic [TAG_W-1:0]   pick_idx;

    // The request register may reload when empty or when drained this cycle.
    assign can_load = ~req_valid_q | l2.l2_req_ready;
    assign accept   = req_valid_q & l2.l2_req_ready;
    assign pend     = miss_filled & ~outstanding_q;

    dmiss_rr_pick #(
        .ENTRIES (ENTRIES),
        .TAG_W   (TAG_W)
    ) u_pick (
        .pend_i   (pend),
        .rr_ptr_i (rr_ptr_q),
        .found_o  (pick_found),
        .idx_o    (pick_idx)
    );

    assign ins_en  = can_load & pick_found;
    assign ins_req = pick_idx;

    // Response clear is evaluated first so a same-tag accept overrides it.
    always_comb begin
        outstanding_d  = outstanding_q;
        err_spurious_d = err_spurious_q;
        if (l2.l2_rsp_valid) begin
            if (outstanding_q[l2.l2_rsp_tag]) begin
                outstanding_d[l2.l2_rsp_tag] = 1'b0;
            end else begin
                err_spurious_d = 1'b1;
            end
        end
        if (accept) begin
            outstanding_d[req_tag_q] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            req_valid_q    <= 1'b0;
            req_addr_q     <= '0;
            req_tag_q      <= '0;
            rr_ptr_q       <= '0;
            outstanding_q  <= '0;
            err_spurious_q <= 1'b0;
        end else begin
            if (ins_en) begin
                req_valid_q <= 1'b1;
                req_addr_q  <= ins_addr_i;
                req_tag_q   <= pick_idx;
                rr_ptr_q    <= pick_idx + TAG_W'(1);
            end else if (accept) begin
                req_valid_q <= 1'b0;
            end
            outstanding_q  <= outstanding_d;
            err_spurious_q <= err_spurious_d;
        end
    end

    // Unlock only once the replay has drained and nothing is still in flight
    // to the L2, otherwise a late fill could land in a released buffer.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= RUN;
            unlock_q <= 1'b0;
        end else begin
            unlock_q <= 1'b0;
            case (state_q)
                RUN: begin
                    if (begin_replay) begin
                        state_q <= REPLAY;
                    end
                end
                REPLAY: begin
                    if (replay_done && (outstanding_q == '0) && !req_valid_q) begin
                        state_q  <= UNLK;
                        unlock_q <= 1'b1;
                    end
                end
                UNLK: begin
                    state_q <= RUN;
                end
                default: begin
                    state_q <= RUN;
                end
            endcase
        end
    end

`ifdef DMISS_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(TIMEOUT);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    logic [CNT_W-1:0] to_cnt_q;
    logic             err_timeout_q;

    // The flag is raised on the same edge the counter reaches TIMEOUT;
    // the counter then saturates until a response or an empty set.
    always_ff @(posedge clk) begin
        if (rst) begin
            to_cnt_q      <= '0;
            err_timeout_q <= 1'b0;
        end else if (l2.l2_rsp_valid || (outstanding_q == '0)) begin
            to_cnt_q <= '0;
        end else if (to_cnt_q != CNT_MAX) begin
            to_cnt_q <= to_cnt_q + CNT_W'(1);
            if (to_cnt_q == CNT_LAST) begin
                err_timeout_q <= 1'b1;
            end
        end
    end

    assign err_timeout = err_timeout_q;
`else
    assign err_timeout = 1'b0;
`endif

    assign l2.l2_req_valid = req_valid_q;
    assign l2.l2_req_addr  = req_addr_q;
    assign l2.l2_req_tag   = req_tag_q;
    assign unlock          = unlock_q;
    assign outstanding     = outstanding_q;
    assign err_spurious    = err_spurious_q;

endmodule

// File: tb/tb_dmiss_req_seq.sv
// tb/tb_dmiss_req_seq.sv - directed self-checking bench for dmiss_req_seq
module tb_dmiss_req_seq;

`ifdef DMISS_TIMEOUT_EN
    localparam int TB_TIMEOUT = 8;
`else
    localparam int TB_TIMEOUT = 1023;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] miss_filled;
    logic [36:0] ins_addr_i;
    logic        ins_en;
    logic [3:0]  ins_req;
    logic        begin_replay;
    logic        replay_done;
    logic        unlock;
    logic [15:0] outstanding;
    logic        err_spurious;
    logic        err_timeout;

    int checks   = 0;
    int failures = 0;

    dmiss_req_seq_if #(.TAG_W(4), .ADDR_W(37)) l2 ();

    dmiss_req_seq #(
        .ENTRIES (16),
        .TAG_W   (4),
        .ADDR_W  (37),
        .TIMEOUT (TB_TIMEOUT)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .miss_filled  (miss_filled),
        .ins_addr_i   (ins_addr_i),
        .ins_en       (ins_en),
        .ins_req      (ins_req),
        .l2           (l2.master),
        .begin_replay (begin_replay),
        .replay_done  (replay_done),
        .unlock       (unlock),
        .outstanding  (outstanding),
        .err_spurious (err_spurious),
        .err_timeout  (err_timeout)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic rsp(input logic [3:0] tag);
        l2.l2_rsp_valid = 1'b1;
        l2.l2_rsp_tag   = tag;
        tick();
        l2.l2_rsp_valid = 1'b0;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_ins_en"}, 64'(ins_en), 64'h0);
        chk({tag, "_valid"},  64'(l2.l2_req_valid), 64'h0);
        chk({tag, "_addr"},   64'(l2.l2_req_addr), 64'h0);
        chk({tag, "_tag"},    64'(l2.l2_req_tag), 64'h0);
        chk({tag, "_outst"},  64'(outstanding), 64'h0);
        chk({tag, "_unlock"}, 64'(unlock), 64'h0);
        chk({tag, "_espur"},  64'(err_spurious), 64'h0);
        chk({tag, "_etime"},  64'(err_timeout), 64'h0);
    endtask

    initial begin
        rst             = 1'b1;
        miss_filled     = '0;
        ins_addr_i      = '0;
        begin_replay    = 1'b0;
        replay_done     = 1'b0;
        l2.l2_req_ready = 1'b0;
        l2.l2_rsp_valid = 1'b0;
        l2.l2_rsp_tag   = '0;
        tick();
        tick();
        chk_all_zero("reset");
        rst = 1'b0;

        // 1: single request, latency through to outstanding
        miss_filled     = 16'h0001;
        ins_addr_i      = 37'h12345;
        l2.l2_req_ready = 1'b1;
        #1;
        chk("t1_c0_ins_en", 64'(ins_en), 64'h1);
        chk("t1_c0_ins_req", 64'(ins_req), 64'h0);
        tick();
        miss_filled = 16'h0000;
        chk("t1_c1_valid", 64'(l2.l2_req_valid), 64'h1);
        chk("t1_c1_addr", 64'(l2.l2_req_addr), 64'h12345);
        chk("t1_c1_tag", 64'(l2.l2_req_tag), 64'h0);
        chk("t1_c1_outst", 64'(outstanding), 64'h0);
        tick();
        chk("t1_c2_outst", 64'(outstanding), 64'h0001);
        chk("t1_c2_valid", 64'(l2.l2_req_valid), 64'h0);
        rsp(4'd0);
        chk("t1_rsp_clear", 64'(outstanding), 64'h0);
        chk("t1_no_spur", 64'(err_spurious), 64'h0);

        // 2: round robin from rr_ptr=0 over 16'h8003
        rst = 1'b1;
        tick();
        rst = 1'b0;
        miss_filled = 16'h8003;
        ins_addr_i  = 37'h0a0;
        #1;
        chk("t2_pick0", 64'(ins_req), 64'h0);
        tick();
        miss_filled = 16'h8002;
        #1;
        chk("t2_pick1", 64'(ins_req), 64'h1);
        chk("t2_tag0", 64'(l2.l2_req_tag), 64'h0);
        tick();
        miss_filled = 16'h8000;
        #1;
        chk("t2_pick15", 64'(ins_req), 64'hf);
        chk("t2_tag1", 64'(l2.l2_req_tag), 64'h1);
        chk("t2_outst_a", 64'(outstanding), 64'h0001);
        tick();
        miss_filled = 16'h0000;
        #1;
        chk("t2_tag15", 64'(l2.l2_req_tag), 64'hf);
        chk("t2_idle", 64'(ins_en), 64'h0);
        chk("t2_outst_b", 64'(outstanding), 64'h0003);
        tick();
        chk("t2_outst_c", 64'(outstanding), 64'h8003);
        rsp(4'd0);
        rsp(4'd1);
        rsp(4'd15);
        chk("t2_drained", 64'(outstanding), 64'h0);
        miss_filled = 16'h8001;
        #1;
        chk("t2_wrap", 64'(ins_req), 64'h0);
        miss_filled = 16'h0000;

        // 3: backpressure for 5 cycles, then back-to-back
        l2.l2_req_ready = 1'b0;
        miss_filled     = 16'h0030;
        ins_addr_i      = 37'h444;
        #1;
        chk("t3_first_pick", 64'(ins_req), 64'h4);
        tick();
        miss_filled = 16'h0020;
        ins_addr_i  = 37'h555;
        for (int i = 0; i < 5; i++) begin
            #1;
            chk("t3_hold_valid", 64'(l2.l2_req_valid), 64'h1);
            chk("t3_hold_tag", 64'(l2.l2_req_tag), 64'h4);
            chk("t3_hold_addr", 64'(l2.l2_req_addr), 64'h444);
            chk("t3_hold_ins_en", 64'(ins_en), 64'h0);
            if (i < 4) tick();
        end
        l2.l2_req_ready = 1'b1;
        #1;
        chk("t3_b2b_ins_en", 64'(ins_en), 64'h1);
        chk("t3_b2b_ins_req", 64'(ins_req), 64'h5);
        tick();
        miss_filled = 16'h0000;
        chk("t3_second_tag", 64'(l2.l2_req_tag), 64'h5);
        chk("t3_second_addr", 64'(l2.l2_req_addr), 64'h555);
        chk("t3_outst_a", 64'(outstanding), 64'h0010);
        tick();
        chk("t3_outst_b", 64'(outstanding), 64'h0030);
        rsp(4'd4);
        rsp(4'd5);
        chk("t3_drained", 64'(outstanding), 64'h0);

        // 4: spurious response, then accept/response collision on tag 2
        rsp(4'd3);
        chk("t4_spur", 64'(err_spurious), 64'h1);
        chk("t4_outst", 64'(outstanding), 64'h0);
        l2.l2_req_ready = 1'b0;
        miss_filled     = 16'h0004;
        #1;
        chk("t4_pick2", 64'(ins_req), 64'h2);
        tick();
        miss_filled     = 16'h0000;
        l2.l2_req_ready = 1'b1;
        rsp(4'd2);
        chk("t4_set_wins", 64'(outstanding), 64'h0004);
        chk("t4_spur_sticky", 64'(err_spurious), 64'h1);
        rsp(4'd2);
        chk("t4_cleared", 64'(outstanding), 64'h0);

        // 5: replay waits for the tag-5 fill
        miss_filled = 16'h0020;
        tick();
        miss_filled = 16'h0000;
        tick();
        chk("t5_outst", 64'(outstanding), 64'h0020);
        begin_replay = 1'b1;
        tick();
        begin_replay = 1'b0;
        replay_done  = 1'b1;
        for (int i = 0; i < 4; i++) begin
            chk("t5_wait_unlock", 64'(unlock), 64'h0);
            tick();
        end
        rsp(4'd5);
        chk("t5_unlock_pre", 64'(unlock), 64'h0);
        tick();
        chk("t5_unlock_hi", 64'(unlock), 64'h1);
        tick();
        chk("t5_unlock_lo", 64'(unlock), 64'h0);
        tick();
        chk("t5_unlock_lo2", 64'(unlock), 64'h0);
        replay_done = 1'b0;

        // 6: watchdog (when built in) and reset mid-wait
        miss_filled = 16'h0040;
        tick();
        miss_filled = 16'h0000;
        tick();
        chk("t6_outst", 64'(outstanding), 64'h0040);
`ifdef DMISS_TIMEOUT_EN
        for (int i = 1; i < 8; i++) begin
            tick();
            chk("t6_timeout_lo", 64'(err_timeout), 64'h0);
        end
        tick();
        chk("t6_timeout_hi", 64'(err_timeout), 64'h1);
        tick();
        chk("t6_timeout_sticky", 64'(err_timeout), 64'h1);
`else
        tick();
        chk("t6_timeout_tied", 64'(err_timeout), 64'h0);
`endif
        begin_replay = 1'b1;
        tick();
        begin_replay    = 1'b0;
        l2.l2_req_ready = 1'b0;
        miss_filled     = 16'h0080;
        tick();
        chk("t6_pending", 64'(l2.l2_req_valid), 64'h1);
        rst         = 1'b1;
        miss_filled = 16'h0000;
        tick();
        rst = 1'b0;
        chk_all_zero("t6_reset");
        replay_done = 1'b1;
        tick();
        tick();
        chk("t6_fsm_run", 64'(unlock), 64'h0);
        begin_replay = 1'b1;
        tick();
        begin_replay = 1'b0;
        tick();
        chk("t6_fsm_unlock", 64'(unlock), 64'h1);
        replay_done = 1'b0;
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
